// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared opcode/funct encodings, exception codes and memory-map
//               defaults for the 5-stage MIPS core.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    typedef logic [4:0] exc_code_t;
    localparam exc_code_t EXC_NONE    = 5'd0;
    localparam exc_code_t EXC_ADEL    = 5'd4;

    localparam logic [31:0] IM_BASE_DEFAULT = 32'h0000_3000;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/bj_detect.sv
`default_nettype none
// ============================================================================
// Module      : bj_detect
// Description : Combinational branch/jump classifier for a 32-bit instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module bj_detect
    import cpu_pkg::*;
(
    input  logic [31:0] instr,
    output logic        is_bj
);

    logic [5:0] w_opcode;
    logic [5:0] w_funct;

    assign w_opcode = instr[31:26];
    assign w_funct  = instr[5:0];

    always_comb begin
        is_bj = 1'b0;
        case (w_opcode)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM,
            OP_J, OP_JAL:  is_bj = 1'b1;
            OP_SPECIAL:    is_bj = (w_funct == FN_JR) || (w_funct == FN_JALR);
            default:       is_bj = 1'b0;
        endcase
    end

endmodule : bj_detect
`default_nettype wire

// File: rtl/fd_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : fd_pipe_reg
// Description : Fetch-to-Decode pipeline register with stall/flush, delay-slot
//               tagging and fetch/stall counters. Define FD_ADDR_CHECK_EN to
//               enable AdEL detection on fetch addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module fd_pipe_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0] IM_BASE  = IM_BASE_DEFAULT,
    parameter int          IM_WORDS = 4096,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] F_pc,
    input  logic [31:0] F_instr,
    output logic [31:0] D_pc,
    output logic [31:0] D_instr,
    output logic        D_valid,
    output logic        D_bd,
    output logic [4:0]  D_exc_code,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
);

    localparam logic [31:0] c_im_last = IM_BASE + 32'(4 * IM_WORDS) - 32'd4;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_valid;
    logic        r_bd;
    exc_code_t   r_exc;
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    logic        w_cur_is_bj;
    logic        w_addr_bad;
    logic        w_adel;

    // Classifies the instruction currently held in D: the next one is its delay slot.
    bj_detect u_bj_detect (
        .instr (r_instr),
        .is_bj (w_cur_is_bj)
    );

    assign w_addr_bad = (F_pc[1:0] != 2'b00) || (F_pc < IM_BASE) || (F_pc > c_im_last);

`ifdef FD_ADDR_CHECK_EN
    assign w_adel = w_addr_bad;
`else
    logic w_unused_addr_bad;
    assign w_unused_addr_bad = w_addr_bad;
    assign w_adel            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= RESET_PC;
            r_instr     <= 32'd0;
            r_valid     <= 1'b0;
            r_bd        <= 1'b0;
            r_exc       <= EXC_NONE;
            r_fetch_cnt <= 32'd0;
            r_stall_cnt <= 32'd0;
        end else if (flush) begin
            r_pc    <= RESET_PC;
            r_instr <= 32'd0;
            r_valid <= 1'b0;
            r_bd    <= 1'b0;
            r_exc   <= EXC_NONE;
        end else if (stall) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end else begin
            r_pc        <= F_pc;
            r_instr     <= w_adel ? 32'd0 : F_instr;
            r_valid     <= 1'b1;
            r_bd        <= r_valid & w_cur_is_bj;
            r_exc       <= w_adel ? EXC_ADEL : EXC_NONE;
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign D_pc       = r_pc;
    assign D_instr    = r_instr;
    assign D_valid    = r_valid;
    assign D_bd       = r_bd;
    assign D_exc_code = r_exc;
    assign fetch_cnt  = r_fetch_cnt;
    assign stall_cnt  = r_stall_cnt;

endmodule : fd_pipe_reg
`default_nettype wire

// File: tb/tb_fd_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_fd_pipe_reg
// Description : Directed self-checking bench for fd_pipe_reg.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fd_pipe_reg;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] F_pc;
    logic [31:0] F_instr;
    logic [31:0] D_pc;
    logic [31:0] D_instr;
    logic        D_valid;
    logic        D_bd;
    logic [4:0]  D_exc_code;
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    fd_pipe_reg dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .F_pc       (F_pc),
        .F_instr    (F_instr),
        .D_pc       (D_pc),
        .D_instr    (D_instr),
        .D_valid    (D_valid),
        .D_bd       (D_bd),
        .D_exc_code (D_exc_code),
        .fetch_cnt  (fetch_cnt),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] pc, input logic [31:0] instr);
        F_pc    = pc;
        F_instr = instr;
        step();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"},    D_pc,               32'h0);
        check({tag, "_instr"}, D_instr,            32'h0);
        check({tag, "_valid"}, 32'(D_valid),       32'h0);
        check({tag, "_bd"},    32'(D_bd),          32'h0);
        check({tag, "_exc"},   32'(D_exc_code),    32'h0);
    endtask

    logic [31:0] exp_exc;
    logic [31:0] exp_instr_a;
    logic [31:0] exp_instr_b;

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        F_pc = 32'h0; F_instr = 32'h0;
        step();
        check_reset_state("rst");
        check("rst_fetch", fetch_cnt, 32'd0);
        check("rst_stall", stall_cnt, 32'd0);

        // Three plain loads
        reset = 1'b0;
        load(32'h3000, 32'h3C01_1234);
        check("ld1_pc", D_pc, 32'h3000);
        check("ld1_valid", 32'(D_valid), 32'd1);
        load(32'h3004, 32'h3C01_1234);
        check("ld2_pc", D_pc, 32'h3004);
        load(32'h3008, 32'h3C01_1234);
        check("ld3_pc", D_pc, 32'h3008);
        check("ld3_instr", D_instr, 32'h3C01_1234);
        check("ld3_bd", 32'(D_bd), 32'd0);
        check("ld3_fetch", fetch_cnt, 32'd3);

        // beq then delay slot
        load(32'h3000, 32'h1022_0003);
        check("beq_bd", 32'(D_bd), 32'd0);
        load(32'h3004, 32'h3404_0001);
        check("slot_bd", 32'(D_bd), 32'd1);
        check("slot_pc", D_pc, 32'h3004);
        load(32'h3008, 32'h3404_0001);
        check("after_slot_bd", 32'(D_bd), 32'd0);
        check("after_slot_fetch", fetch_cnt, 32'd6);

        // jr held through a 4-cycle stall; its slot is tagged after release
        load(32'h3004, 32'h03E0_0008);
        stall = 1'b1;
        F_pc = 32'h3008; F_instr = 32'h3404_0001;
        repeat (4) step();
        check("stall_pc", D_pc, 32'h3004);
        check("stall_instr", D_instr, 32'h03E0_0008);
        check("stall_valid", 32'(D_valid), 32'd1);
        check("stall_cnt4", stall_cnt, 32'd4);
        check("stall_fetch", fetch_cnt, 32'd7);
        stall = 1'b0;
        step();
        check("release_pc", D_pc, 32'h3008);
        check("release_bd_jr", 32'(D_bd), 32'd1);
        check("release_fetch", fetch_cnt, 32'd8);

        // jal then regimm
        load(32'h300C, 32'h0C00_0C00);
        check("jal_bd", 32'(D_bd), 32'd0);
        load(32'h3010, 32'h0411_0001);
        check("jal_slot_bd", 32'(D_bd), 32'd1);
        check("pre_flush_pc", D_pc, 32'h3010);

        // flush beats stall
        stall = 1'b1; flush = 1'b1;
        F_pc = 32'h3014; F_instr = 32'h3404_0001;
        step();
        check_reset_state("flush");
        check("flush_stall_cnt", stall_cnt, 32'd4);
        check("flush_fetch", fetch_cnt, 32'd10);
        stall = 1'b0; flush = 1'b0;
        load(32'h3014, 32'h3404_0001);
        check("post_flush_bd", 32'(D_bd), 32'd0);
        check("post_flush_valid", 32'(D_valid), 32'd1);

        // Fetch address checks
`ifdef FD_ADDR_CHECK_EN
        exp_exc = 32'd4; exp_instr_a = 32'h0; exp_instr_b = 32'h0;
`else
        exp_exc = 32'd0; exp_instr_a = 32'h3404_0001; exp_instr_b = 32'h3C01_1234;
`endif
        load(32'h3002, 32'h3404_0001);
        check("misalign_exc", 32'(D_exc_code), exp_exc);
        check("misalign_instr", D_instr, exp_instr_a);
        check("misalign_pc", D_pc, 32'h3002);
        check("misalign_valid", 32'(D_valid), 32'd1);
        load(32'h2FFC, 32'h3C01_1234);
        check("below_exc", 32'(D_exc_code), exp_exc);
        check("below_instr", D_instr, exp_instr_b);
        load(32'h6FFC, 32'h3404_0001);
        check("top_legal_exc", 32'(D_exc_code), 32'd0);
        check("top_legal_instr", D_instr, 32'h3404_0001);
        load(32'h7000, 32'h3C01_1234);
        check("above_exc", 32'(D_exc_code), exp_exc);
        check("above_instr", D_instr, exp_instr_b);
        check("addr_fetch", fetch_cnt, 32'd15);

        // Fetch counter wrap
        stall = 1'b1;
        force dut.r_fetch_cnt = 32'hFFFF_FFFF;
        step();
        release dut.r_fetch_cnt;
        #1;
        check("preload_fetch", fetch_cnt, 32'hFFFF_FFFF);
        stall = 1'b0;
        load(32'h3000, 32'h3C01_1234);
        check("wrap_fetch", fetch_cnt, 32'd0);
        check("wrap_stall_cnt", stall_cnt, 32'd5);

        // Reset in the middle of a stall
        stall = 1'b1;
        step();
        check("midstall_cnt", stall_cnt, 32'd6);
        reset = 1'b1;
        step();
        check_reset_state("midrst");
        check("midrst_fetch", fetch_cnt, 32'd0);
        check("midrst_stall", stall_cnt, 32'd0);
        reset = 1'b0; stall = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_fd_pipe_reg
`default_nettype wire
